gpio_input_debouncer: RTL and testbench

//   Conditions the raw FPGA slide-switch inputs (SW[15:0]) before they reach
//   the rv32i_soc GPIO inputs (io_data[31:16]).

---
 rtl/gpio_input_debouncer.sv | 93 +++++++++
 tb/tb_gpio_input_debouncer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_debouncer.sv
// Slide-switch conditioner: per-bit synchronizer, stability-count debounce,
// and registered rise/fall/change strobes for the GPIO input path.
module gpio_input_debouncer #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  localparam int unsigned CNT_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_RAW == 0) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             change_q, change_d;
  logic [WIDTH-1:0] syn;

  // Synchronizer chain: pure wiring between stages, no logic in the path.
  always_comb begin
    sync_d[0] = raw_i;
    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign syn = sync_q[SYNC_STAGES-1];

  // Per-bit stability counters; a change is accepted on the Dth consecutive mismatch.
  always_comb begin
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (syn[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]  = '0;
        sw_d[i]   = syn[i];
        rise_d[i] = syn[i];
        fall_d[i] = ~syn[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
      sw_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sw_q     <= sw_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign sw_o     = sw_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Directed + randomized bench for gpio_input_debouncer against a sliding-window
// reference: a bit flips once its last D synchronized samples all disagree with it.
module tb_gpio_input_debouncer;

  localparam int unsigned W = 4;
  localparam int unsigned S = 2;
  localparam int unsigned D = 4;

  logic         clk_i = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw_i;
  logic [W-1:0] sw_o, rise_o, fall_o;
  logic         change_o;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_input_debouncer #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_i(clk_i), .reset_n(reset_n), .raw_i(raw_i),
    .sw_o(sw_o), .rise_o(rise_o), .fall_o(fall_o), .change_o(change_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] syn_hist[$];
  logic [W-1:0] m_sw, m_rise, m_fall;
  logic         m_change;

  task automatic model_reset();
    raw_hist.delete();
    syn_hist.delete();
    for (int k = 0; k < int'(S); k++) raw_hist.push_back('0);
    m_sw = '0; m_rise = '0; m_fall = '0; m_change = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] syn_now;
    bit flip;
    syn_now = raw_hist[0];
    raw_hist.push_back(raw_i);
    void'(raw_hist.pop_front());
    syn_hist.push_back(syn_now);
    if (syn_hist.size() > int'(D)) void'(syn_hist.pop_front());
    m_rise = '0;
    m_fall = '0;
    if (syn_hist.size() == int'(D)) begin
      for (int b = 0; b < int'(W); b++) begin
        flip = 1'b1;
        for (int k = 0; k < int'(D); k++) begin
          if (syn_hist[k][b] == m_sw[b]) flip = 1'b0;
        end
        if (flip) begin
          m_sw[b] = ~m_sw[b];
          if (m_sw[b]) m_rise[b] = 1'b1;
          else         m_fall[b] = 1'b1;
        end
      end
    end
    m_change = |(m_rise | m_fall);
  endtask

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    cmp("sw_o", sw_o, m_sw);
    cmp("rise_o", rise_o, m_rise);
    cmp("fall_o", fall_o, m_fall);
    cmp("change_o", {{(W-1){1'b0}}, change_o}, {{(W-1){1'b0}}, m_change});
  endtask

  // One clock: advance the model on the edge, then sample 1 time unit later.
  task automatic tick(input bit adv);
    @(posedge clk_i);
    if (adv) model_edge();
    #1;
    check_model();
  endtask

  task automatic settle(input logic [W-1:0] v);
    raw_i = v;
    repeat (2 * (S + D)) tick(1'b1);
  endtask

  initial begin
    int first;
    int pulses;
    logic [W-1:0] bounce [12];

    // 1. reset with switches high
    reset_n = 1'b0;
    raw_i   = 4'hF;
    model_reset();
    #2;
    check_model();
    repeat (3) tick(1'b0);
    @(negedge clk_i);
    reset_n = 1'b1;
    first = -1; pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      tick(1'b1);
      if (first < 0 && sw_o === 4'hF) begin
        first = e;
        cmp("t1_rise_val", rise_o, 4'hF);
      end
      if (change_o) pulses++;
    end
    cmp_int("t1_latency", first, 6);
    cmp_int("t1_change_pulses", pulses, 1);

    // 2. short pulse on bit 0 is rejected
    settle(4'h0);
    pulses = 0;
    raw_i = 4'b0001;
    for (int e = 0; e < 3; e++) begin tick(1'b1); if (change_o || sw_o != 0) pulses++; end
    raw_i = 4'b0000;
    for (int e = 0; e < 10; e++) begin tick(1'b1); if (change_o || sw_o != 0) pulses++; end
    cmp_int("t2_glitch_seen", pulses, 0);

    // 3. bit 1 rise then fall
    raw_i = 4'b0010;
    first = -1;
    for (int e = 1; e <= 10; e++) begin
      tick(1'b1);
      if (first < 0 && sw_o[1]) begin first = e; cmp("t3_rise_val", rise_o, 4'b0010); end
    end
    cmp_int("t3_rise_latency", first, 6);
    raw_i = 4'b0000;
    first = -1;
    for (int e = 1; e <= 10; e++) begin
      tick(1'b1);
      if (first < 0 && !sw_o[1]) begin first = e; cmp("t3_fall_val", fall_o, 4'b0010); end
    end
    cmp_int("t3_fall_latency", first, 6);

    // 4. bit 2 bounces 1,0 then holds 1: count restarts after the 0
    for (int j = 0; j < 12; j++) bounce[j] = 4'b0100;
    bounce[1] = 4'b0000;
    first = -1;
    for (int j = 0; j < 12; j++) begin
      raw_i = bounce[j];
      tick(1'b1);
      if (first < 0 && sw_o[2]) first = j;
    end
    cmp_int("t4_bounce_edge", first, 7);

    // 5. bits 0 and 2 rise together
    settle(4'h0);
    raw_i = 4'b0101;
    first = -1; pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      tick(1'b1);
      if (change_o) pulses++;
      if (first < 0 && sw_o === 4'b0101) begin first = e; cmp("t5_rise_val", rise_o, 4'b0101); end
    end
    cmp_int("t5_latency", first, 6);
    cmp_int("t5_change_pulses", pulses, 1);

    // 6. async reset while bit 3 is mid-count
    raw_i = 4'b1101;
    repeat (4) tick(1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model();
    cmp("t6_sw_async", sw_o, 4'h0);
    repeat (2) tick(1'b0);
    @(negedge clk_i);
    reset_n = 1'b1;
    first = -1;
    for (int e = 1; e <= 10; e++) begin
      tick(1'b1);
      if (first < 0 && sw_o === 4'b1101) begin first = e; cmp("t6_rise_val", rise_o, 4'b1101); end
    end
    cmp_int("t6_latency", first, 6);

    // Random phase: sparse toggles plus occasional short glitches
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) raw_i[$urandom_range(0, W-1)] ^= 1'b1;
      tick(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
